mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory-subsystem port (SPI SRAM / UART / I2C / GPIO / LO map) between two requesters.
//  Requester 0 is the CPU core (fetch + load/store); requester 1 is a DMA/boot-loader master.
//  Sequences each access as one ce pulse followed by a wait for valid.
//  Guards every access with a watchdog so a hung peripheral cannot stall the CPU.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  cycles in WAIT before an access is aborted with error; must be >= 2
// PORTS
//  clk           in   1   clock
//  reset         in   1   synchronous, active-low reset
//  m{0,1}_req    in   1   access request; level, held until m{0,1}_valid
//  m{0,1}_addr   in   32  byte address; stable while req=1
//  m{0,1}_wdata  in   32  store data; stable while req=1
//  m{0,1}_we     in   1   1=store, 0=load/fetch
//  m{0,1}_funct3 in   3   access size/sign code (FUNCT3_MEM_* encoding)
//  m{0,1}_rdata  out  32  load data; meaningful only when m{0,1}_valid=1
//  m{0,1}_valid  out  1   one-cycle completion pulse
//  m{0,1}_err    out  1   one-cycle timeout-abort flag; coincides with valid
//  m{0,1}_busy   out  1   request pending or in flight for this master
//  mem_ce        out  1   one-cycle access start to memory subsystem
//  mem_addr      out  32  muxed from granted master
//  mem_datain    out  32  muxed from granted master
//  mem_memwrite  out  1   granted master's we, gated by ISSUE/WAIT states
//  mem_funct3    out  3   muxed from granted master
//  mem_dataout   in   32  memory read data
//  mem_busy      in   1   memory subsystem busy
//  mem_valid     in   1   memory completion pulse
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, grant=0, last_grant=1, timer=0.
//    All outputs 0; mem_* mux outputs driven from master 0 with mem_memwrite=0.
//  - States: IDLE -> ISSUE -> WAIT -> IDLE.
//    IDLE: if any req, register grant; next state ISSUE.
//    ISSUE: mem_ce=1 for exactly this cycle; clear timer; next state WAIT.
//    WAIT: timer increments each cycle.
//      If mem_valid=1: mK_valid=1 and mK_rdata=mem_dataout in the same (combinational) cycle; next state IDLE.
//      Else if timer==TIMEOUT_CYCLES-1: mK_valid=1, mK_err=1, mK_rdata=0; next state IDLE.
//  - Latency: req rising in cycle N -> mem_ce in N+1 -> valid no earlier than N+2.
//    After valid, one IDLE cycle precedes the next grant.
//  - Master requirements: a master drops req in the cycle after its valid or keeps it high for a new access.
//    Inputs of the granted master are muxed through unregistered.
//  - mem_busy is ignored for sequencing; it only ORs into mK_busy of the granted master.
//  - mK_busy = mK_req | (grant==K & state!=IDLE).
//  - The ungranted master's valid/err/rdata stay 0.
//  - Simultaneous mem_valid and timeout: valid wins (err=0).
//  - req dropped mid-access: the access still completes; the valid pulse is still emitted.
//  - Reset mid-access: abort immediately to IDLE. No valid is emitted. mem_ce is never re-pulsed for the aborted access.
//  - Timer width: $clog2(TIMEOUT_CYCLES); it never wraps, because leaving WAIT clears it.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN undefined: fixed priority; m0 (CPU) wins every simultaneous request.
//  ARB_ROUND_ROBIN_EN defined: on simultaneous requests the master != last_grant wins.
//    last_grant updates on every transition IDLE -> ISSUE.
//  A single request is granted identically in both modes.
// STRUCTURE
//  Shared package: arb_state_t enum {IDLE, ISSUE, WAIT}.
//  FUNCT3_MEM_* constants stay in the existing shared constants package.
//  Sub-module mem_arb_watchdog (clear/enable in, expired out, TIMEOUT_CYCLES param) holds the timer.
//  Grant/mux/FSM logic stays in this module.
// TESTING
//  1. m0 load only, addr=0x100, memory valid 3 cycles after ce, data 0xDEADBEEF
//     -> mem_ce at N+1, m0_valid + rdata=0xDEADBEEF at N+4, m0_err=0.
//  2. m0 and m1 req in the same cycle, 4 back-to-back accesses
//     -> fixed: m0,m0,m0,m0; with ARB_ROUND_ROBIN_EN: m0,m1,m0,m1.
//  3. m1 store addr=0x2000 wdata=0x12345678 funct3=SW
//     -> mem_memwrite=1, mem_datain=0x12345678 during ISSUE/WAIT; m0 outputs stay 0.
//  4. TIMEOUT_CYCLES=8, memory never answers
//     -> m0_valid=1, m0_err=1, rdata=0 exactly 8 cycles after ISSUE; next m1 request is served normally.
//  5. reset=0 asserted during WAIT, mem_valid arrives in the following cycle
//     -> no valid/err pulse; all outputs 0; state IDLE.
//  6. mem_valid in the same cycle as timer expiry
//     -> valid=1, err=0, rdata=mem_dataout.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the two-master memory port arbiter.
// Access-size codes mirror the FUNCT3_MEM_* encoding used by the core's load/store unit.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic [2:0] FUNCT3_MEM_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_MEM_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_MEM_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_MEM_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_MEM_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_MEM_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_MEM_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_MEM_SW  = 3'b010;

    // Winner of an arbitration round; only meaningful when at least one request is set.
    function automatic logic pick_grant(input logic req0, input logic req1,
                                        input logic last_grant, input bit round_robin);
        if (req0 && req1) begin
            return round_robin ? ~last_grant : 1'b0;
        end
        return req0 ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Access watchdog: counts cycles while enabled and flags the last allowed cycle.
// Clear has priority over enable; the count saturates so it can never wrap.
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned TimerW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TimerW-1:0] LastCount = TimerW'(TIMEOUT_CYCLES - 1);

    logic [TimerW-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q;
        if (!reset || clr) begin
            timer_d = '0;
        end else if (en && (timer_q != LastCount)) begin
            timer_d = timer_q + TimerW'(1);
        end
    end

    always_ff @(posedge clk) begin
        timer_q <= timer_d;
    end

    always_comb begin
        expired = (timer_q == LastCount);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the shared memory-subsystem port: one ce pulse per access, then wait
// for valid under a watchdog. Define ARB_ROUND_ROBIN_EN for round-robin; default is m0 priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    input  logic [2:0]  m0_funct3,
    output logic [31:0] m0_rdata,
    output logic        m0_valid,
    output logic        m0_err,
    output logic        m0_busy,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    input  logic [2:0]  m1_funct3,
    output logic [31:0] m1_rdata,
    output logic        m1_valid,
    output logic        m1_err,
    output logic        m1_busy,

    output logic        mem_ce,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_datain,
    output logic        mem_memwrite,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_dataout,
    input  logic        mem_busy,
    input  logic        mem_valid
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RoundRobin = 1'b1;
`else
    localparam bit RoundRobin = 1'b0;
`endif

    arb_state_t state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;

    logic       running;
    logic       sel;
    logic       expired;
    logic       in_wait;
    logic       done;
    logic       timed_out;
    logic       wd_clr;
    logic       wd_en;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (expired)
    );

    // Timer is held at zero outside WAIT, so entering WAIT from ISSUE always starts at 0.
    always_comb begin
        wd_clr = (state_q != WAIT);
        wd_en  = (state_q == WAIT);
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_d      = pick_grant(m0_req, m1_req, last_grant_q, RoundRobin);
                    last_grant_d = grant_d;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_valid || expired) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!reset) begin
            state_d      = IDLE;
            grant_d      = 1'b0;
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        grant_q      <= grant_d;
        last_grant_q <= last_grant_d;
    end

    // While reset is held every output is forced quiet, which also kills a late mem_valid.
    always_comb begin
        running   = reset;
        sel       = running & grant_q;
        in_wait   = running && (state_q == WAIT);
        done      = in_wait && (mem_valid || expired);
        timed_out = in_wait && !mem_valid && expired;
    end

    always_comb begin
        mem_addr     = sel ? m1_addr   : m0_addr;
        mem_datain   = sel ? m1_wdata  : m0_wdata;
        mem_funct3   = sel ? m1_funct3 : m0_funct3;
        mem_memwrite = running && (state_q != IDLE) && (sel ? m1_we : m0_we);
        mem_ce       = running && (state_q == ISSUE);
    end

    always_comb begin
        m0_valid = done && !grant_q;
        m1_valid = done && grant_q;
        m0_err   = timed_out && !grant_q;
        m1_err   = timed_out && grant_q;
        m0_rdata = (m0_valid && mem_valid) ? mem_dataout : 32'h0;
        m1_rdata = (m1_valid && mem_valid) ? mem_dataout : 32'h0;
    end

    always_comb begin
        m0_busy = running && (m0_req || (!grant_q && ((state_q != IDLE) || mem_busy)));
        m1_busy = running && (m1_req || (grant_q && ((state_q != IDLE) || mem_busy)));
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction table plus hand-written corner sequences.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned Timeout = 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RrMode = 1'b1;
`else
    localparam bit RrMode = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_we, m1_we;
    logic [2:0]  m0_funct3, m1_funct3;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_valid, m1_valid, m0_err, m1_err, m0_busy, m1_busy;
    logic        mem_ce, mem_memwrite, mem_busy, mem_valid;
    logic [31:0] mem_addr, mem_datain, mem_dataout;
    logic [2:0]  mem_funct3;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .m0_req       (m0_req),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_we        (m0_we),
        .m0_funct3    (m0_funct3),
        .m0_rdata     (m0_rdata),
        .m0_valid     (m0_valid),
        .m0_err       (m0_err),
        .m0_busy      (m0_busy),
        .m1_req       (m1_req),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_we        (m1_we),
        .m1_funct3    (m1_funct3),
        .m1_rdata     (m1_rdata),
        .m1_valid     (m1_valid),
        .m1_err       (m1_err),
        .m1_busy      (m1_busy),
        .mem_ce       (mem_ce),
        .mem_addr     (mem_addr),
        .mem_datain   (mem_datain),
        .mem_memwrite (mem_memwrite),
        .mem_funct3   (mem_funct3),
        .mem_dataout  (mem_dataout),
        .mem_busy     (mem_busy),
        .mem_valid    (mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    typedef struct {
        int          master;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        int          delay;      // cycles from ce to mem_valid; <0 means memory never answers
        logic [31:0] data;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_cycle;  // completion cycle counted from the request cycle
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        logic        vk, ek, bk, vo, eo;
        logic [31:0] rk, ro;
        bit          seen;
        next_cycle();
        if (v.master == 0) begin
            m0_req = 1'b1; m0_addr = v.addr; m0_wdata = v.wdata; m0_we = v.we; m0_funct3 = v.f3;
        end else begin
            m1_req = 1'b1; m1_addr = v.addr; m1_wdata = v.wdata; m1_we = v.we; m1_funct3 = v.f3;
        end
        mem_dataout = v.data;
        seen = 1'b0;
        for (int c = 0; c < 14 && !seen; c++) begin
            if (c > 0) next_cycle();
            mem_valid = (v.delay > 0) && (c == 1 + v.delay);
            @(negedge clk);
            vk = (v.master == 0) ? m0_valid : m1_valid;
            ek = (v.master == 0) ? m0_err   : m1_err;
            rk = (v.master == 0) ? m0_rdata : m1_rdata;
            bk = (v.master == 0) ? m0_busy  : m1_busy;
            vo = (v.master == 0) ? m1_valid : m0_valid;
            eo = (v.master == 0) ? m1_err   : m0_err;
            ro = (v.master == 0) ? m1_rdata : m0_rdata;
            if (c == 0) begin
                check("ce_idle", mem_ce, 0);
                check("busy_pending", bk, 1);
            end
            if (c == 1) begin
                check("ce_issue", mem_ce, 1);
                check("addr_issue", mem_addr, v.addr);
                check("datain_issue", mem_datain, v.wdata);
                check("funct3_issue", mem_funct3, v.f3);
                check("memwrite_issue", mem_memwrite, v.we);
            end
            if (c == 2) begin
                check("ce_wait", mem_ce, 0);
                check("memwrite_wait", mem_memwrite, v.we);
            end
            if (vk) begin
                seen = 1'b1;
                check("valid_cycle", c, v.exp_cycle);
                check("err", ek, v.exp_err);
                check("rdata", rk, v.exp_rdata);
                check("other_valid", vo, 0);
                check("other_err", eo, 0);
                check("other_rdata", ro, 0);
            end
        end
        if (!seen) check("valid_seen", 0, 1);
        next_cycle();
        mem_valid = 1'b0;
        if (v.master == 0) m0_req = 1'b0; else m1_req = 1'b0;
        @(negedge clk);
        check("busy_after", (v.master == 0) ? m0_busy : m1_busy, 0);
        check("ce_after", mem_ce, 0);
    endtask

    initial begin
        bit found;
        bit ce_seen;
        int exp_m;

        vecs[0] = '{0, 1'b0, 32'h0000_0100, 32'h0, FUNCT3_MEM_LW, 3,
                    32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 4};
        vecs[1] = '{1, 1'b1, 32'h0000_2000, 32'h1234_5678, FUNCT3_MEM_SW, 2,
                    32'h5555_AAAA, 1'b0, 32'h5555_AAAA, 3};
        vecs[2] = '{0, 1'b0, 32'h0000_0300, 32'h0, FUNCT3_MEM_LW, -1,
                    32'hFFFF_FFFF, 1'b1, 32'h0, 9};
        vecs[3] = '{1, 1'b0, 32'h0000_0400, 32'h0, FUNCT3_MEM_LHU, 1,
                    32'hA5A5_5A5A, 1'b0, 32'hA5A5_5A5A, 2};
        vecs[4] = '{0, 1'b0, 32'h0000_0500, 32'h0, FUNCT3_MEM_LW, 8,
                    32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 9};
        vecs[5] = '{0, 1'b1, 32'h0000_0600, 32'hCAFE_BABE, FUNCT3_MEM_SB, 7,
                    32'h0000_0001, 1'b0, 32'h0000_0001, 8};
        vecs[6] = '{1, 1'b0, 32'h0000_0700, 32'h0, FUNCT3_MEM_LBU, -1,
                    32'h1357_9BDF, 1'b1, 32'h0, 9};

        reset = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        m0_addr = 32'h1111_1111; m1_addr = 32'h2222_2222;
        m0_wdata = 32'h3333_3333; m1_wdata = 32'h4444_4444;
        m0_we = 1'b1; m1_we = 1'b1;
        m0_funct3 = FUNCT3_MEM_SW; m1_funct3 = FUNCT3_MEM_LB;
        mem_dataout = 32'h0; mem_busy = 1'b0; mem_valid = 1'b0;

        // Reset state: quiet outputs, mux parked on master 0.
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_m0_valid", m0_valid, 0);
        check("rst_m1_valid", m1_valid, 0);
        check("rst_err", {m0_err, m1_err}, 0);
        check("rst_ce", mem_ce, 0);
        check("rst_memwrite", mem_memwrite, 0);
        check("rst_busy", {m0_busy, m1_busy}, 0);
        check("rst_addr", mem_addr, 32'h1111_1111);
        check("rst_datain", mem_datain, 32'h3333_3333);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ce", mem_ce, 0);

        // Simultaneous requests held high across four back-to-back accesses.
        next_cycle();
        m0_req = 1'b1; m0_addr = 32'hA000_0000; m0_we = 1'b0; m0_funct3 = FUNCT3_MEM_LW;
        m1_req = 1'b1; m1_addr = 32'hB000_0000; m1_we = 1'b0; m1_funct3 = FUNCT3_MEM_LW;
        for (int i = 0; i < 4; i++) begin
            exp_m = RrMode ? (i % 2) : 0;
            found = 1'b0;
            for (int w = 0; w < 6 && !found; w++) begin
                @(negedge clk);
                if (mem_ce) found = 1'b1;
                else next_cycle();
            end
            check("prio_ce_seen", found, 1);
            check("prio_addr", mem_addr, (exp_m == 0) ? 32'hA000_0000 : 32'hB000_0000);
            next_cycle();
            mem_valid = 1'b1; mem_dataout = 32'h0000_0010 + i;
            @(negedge clk);
            check("prio_valid_winner", (exp_m == 0) ? m0_valid : m1_valid, 1);
            check("prio_valid_loser", (exp_m == 0) ? m1_valid : m0_valid, 0);
            next_cycle();
            mem_valid = 1'b0;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        next_cycle();
        next_cycle();

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // Reset during WAIT with a late mem_valid: nothing may be reported.
        next_cycle();
        m0_req = 1'b1; m0_addr = 32'h0000_0800; m0_we = 1'b0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check("rmid_ce", mem_ce, 1);
        next_cycle();
        reset = 1'b0; m0_req = 1'b0;
        @(negedge clk);
        check("rmid_valid_in_rst", m0_valid, 0);
        check("rmid_memwrite", mem_memwrite, 0);
        check("rmid_busy_in_rst", m0_busy, 0);
        next_cycle();
        reset = 1'b1; mem_valid = 1'b1; mem_dataout = 32'h7777_7777;
        @(negedge clk);
        check("rmid_valid_late", m0_valid, 0);
        check("rmid_err_late", m0_err, 0);
        check("rmid_rdata_late", m0_rdata, 0);
        check("rmid_busy_late", m0_busy, 0);
        next_cycle();
        mem_valid = 1'b0;
        ce_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_ce) ce_seen = 1'b1;
            next_cycle();
        end
        check("rmid_no_reissue", ce_seen, 0);

        run_txn(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
